// File: rtl/spi_bus_arbiter.sv
// Round-robin owner of the shared SPI bus for the flash (c0) and EEPROM (c1) clients; SPI mode 0, MSB first.
// Latency: gnt/CS one cycle after req, ready CS_SETUP cycles later, 16*CLK_DIV cycles per byte, CS_GAP idle after.
// Backpressure: owner's ready is high only in WAIT; a byte is taken on valid&ready, spi_lock blocks new grants.
module spi_bus_arbiter #(
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_GAP   = 4
) (
  input  logic       clk_dot4x,
  input  logic       rst,
  input  logic       spi_lock,
  input  logic       c0_req,
  input  logic       c1_req,
  output logic       c0_gnt,
  output logic       c1_gnt,
  input  logic       c0_valid,
  input  logic       c1_valid,
  input  logic [7:0] c0_data,
  input  logic [7:0] c1_data,
  input  logic       c0_last,
  input  logic       c1_last,
  output logic       c0_ready,
  output logic       c1_ready,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       spi_c,
  output logic       spi_d,
  input  logic       spi_q,
  output logic       flash_s,
  output logic       eeprom_s
);

  localparam int DIV_W   = $clog2(CLK_DIV) + 1;
  localparam int CNT_MAX = (CS_SETUP > CS_GAP) ? CS_SETUP : CS_GAP;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;

  typedef enum logic [2:0] {IDLE, SETUP, WAIT, SHIFT, GAP} state_t;

  state_t           state, state_nxt;
  logic             last_owner;    // also the current owner while a transaction is active
  logic             grant_sel;
  logic [CNT_W-1:0] cnt;
  logic [DIV_W-1:0] div;
  logic [2:0]       bit_cnt;
  logic [7:0]       shreg;
  logic [7:0]       rx_shift;
  logic             last_lat;
  logic             own_req, own_valid, own_last;
  logic [7:0]       own_data;
  logic             busy;
  logic             setup_done, gap_done, phase_end, byte_done;

  // Owner's view of the client interface; the other client's inputs are ignored.
  always_comb begin
    own_req   = last_owner ? c1_req   : c0_req;
    own_valid = last_owner ? c1_valid : c0_valid;
    own_last  = last_owner ? c1_last  : c0_last;
    own_data  = last_owner ? c1_data  : c0_data;
  end

  assign setup_done = (cnt == CNT_W'(CS_SETUP - 1));
  assign gap_done   = (cnt == CNT_W'(CS_GAP - 1));
  assign phase_end  = (div == DIV_W'(CLK_DIV - 1));
  assign byte_done  = phase_end && spi_c && (bit_cnt == 3'd7);

  // Next-state logic, round-robin pick in IDLE, and grant/ready/CS decode.
  always_comb begin
    state_nxt = state;
    grant_sel = last_owner;
    case (state)
      IDLE: begin
        if (!spi_lock && (c0_req || c1_req)) begin
          if (c0_req && c1_req) grant_sel = ~last_owner;
          else                  grant_sel = c1_req;
          state_nxt = SETUP;
        end
      end
      SETUP: if (setup_done) state_nxt = WAIT;
      WAIT: begin
        if (!own_req)       state_nxt = GAP;
        else if (own_valid) state_nxt = SHIFT;
      end
      SHIFT: if (byte_done) state_nxt = (last_lat || !own_req) ? GAP : WAIT;
      GAP:   if (gap_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    busy     = (state == SETUP) || (state == WAIT) || (state == SHIFT);
    c0_gnt   = busy && !last_owner;
    c1_gnt   = busy && last_owner;
    c0_ready = (state == WAIT) && !last_owner;
    c1_ready = (state == WAIT) && last_owner;
    flash_s  = !c0_gnt;
    eeprom_s = !c1_gnt;
  end

  // State register; last_owner starts at 1 so c0 wins the first contested grant.
  always_ff @(posedge clk_dot4x) begin
    if (rst) begin
      state      <= IDLE;
      last_owner <= 1'b1;
    end else begin
      state <= state_nxt;
      if (state == IDLE && state_nxt == SETUP) last_owner <= grant_sel;
    end
  end

  // Setup/gap counter restarts on every state change and saturates instead of wrapping.
  always_ff @(posedge clk_dot4x) begin
    if (rst || state_nxt != state) cnt <= '0;
    else if (cnt != '1)            cnt <= cnt + CNT_W'(1);
  end

  // SPI shifter: MOSI changes with SCK low, MISO sampled on rising SCK, byte reported after the 8th falling edge.
  always_ff @(posedge clk_dot4x) begin
    if (rst) begin
      spi_c    <= 1'b0;
      spi_d    <= 1'b0;
      shreg    <= '0;
      rx_shift <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      div      <= '0;
      bit_cnt  <= '0;
      last_lat <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (state == WAIT && state_nxt == SHIFT) begin
        shreg    <= own_data;
        spi_d    <= own_data[7];
        last_lat <= own_last;
        div      <= '0;
        bit_cnt  <= '0;
        spi_c    <= 1'b0;
      end else if (state == SHIFT) begin
        if (phase_end) begin
          div <= '0;
          if (!spi_c) begin
            spi_c    <= 1'b1;
            rx_shift <= {rx_shift[6:0], spi_q};
          end else begin
            spi_c   <= 1'b0;
            shreg   <= {shreg[6:0], 1'b0};
            spi_d   <= shreg[6];
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              rx_valid <= 1'b1;
              rx_data  <= rx_shift;
            end
          end
        end else begin
          div <= div + DIV_W'(1);
        end
      end
    end
  end

`ifndef SYNTHESIS
  a_cs_exclusive: assert property (@(posedge clk_dot4x) disable iff (rst) !(!flash_s && !eeprom_s));
  a_gnt_exclusive: assert property (@(posedge clk_dot4x) disable iff (rst) !(c0_gnt && c1_gnt));
  a_sck_in_shift: assert property (@(posedge clk_dot4x) disable iff (rst)
    (spi_c != $past(spi_c)) |-> ($past(state) == SHIFT));
  a_mosi_stable: assert property (@(posedge clk_dot4x) disable iff (rst)
    (spi_c && $past(spi_c)) |-> (spi_d == $past(spi_d)));
`endif

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Scenario bench for spi_bus_arbiter: expected rx bytes queued when a transaction starts, popped on rx_valid.
module tb_spi_bus_arbiter;

  localparam int CLK_DIV  = 4;
  localparam int CS_SETUP = 2;
  localparam int CS_GAP   = 4;
  localparam logic [16:0] RST_OUT = {2'b11, 15'b0};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       spi_lock = 1'b0;
  logic       c0_req = 1'b0, c1_req = 1'b0;
  logic       c0_gnt, c1_gnt;
  logic       c0_valid = 1'b0, c1_valid = 1'b0;
  logic [7:0] c0_data = '0, c1_data = '0;
  logic       c0_last = 1'b0, c1_last = 1'b0;
  logic       c0_ready, c1_ready;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       spi_c, spi_d, spi_q;
  logic       flash_s, eeprom_s;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] sb[$];

  // slave model: shifts slv_word out MSB first, advancing after each falling SCK
  logic [31:0] slv_word = '1;
  logic [4:0]  sl_cnt = '0;
  logic        prev_c_sl = 1'b0;
  assign spi_q = slv_word[5'd31 - sl_cnt];

  always @(posedge clk) begin
    prev_c_sl <= spi_c;
    if (flash_s && eeprom_s)    sl_cnt <= '0;
    else if (prev_c_sl && !spi_c) sl_cnt <= sl_cnt + 5'd1;
  end

  // bus monitor, sampled 1 time unit after each rising clock
  int   cyc_now = 0;
  int   both_gnt = 0;
  int   rxv_cnt = 0;
  int   es_rise = 0;
  logic prev_c = 1'b0;
  logic prev_es = 1'b1;
  logic mosi_bits[$];
  int   rise_cyc[$];

  always @(posedge clk) begin
    #1;
    cyc_now++;
    if (!prev_c && spi_c) begin
      mosi_bits.push_back(spi_d);
      rise_cyc.push_back(cyc_now);
    end
    prev_c = spi_c;
    if (c0_gnt && c1_gnt) both_gnt++;
    if (rx_valid) rxv_cnt++;
    if (eeprom_s && !prev_es) es_rise++;
    prev_es = eeprom_s;
  end

  always #5 clk = ~clk;

  spi_bus_arbiter #(.CLK_DIV(CLK_DIV), .CS_SETUP(CS_SETUP), .CS_GAP(CS_GAP)) dut (
    .clk_dot4x(clk), .rst(rst), .spi_lock(spi_lock),
    .c0_req(c0_req), .c1_req(c1_req), .c0_gnt(c0_gnt), .c1_gnt(c1_gnt),
    .c0_valid(c0_valid), .c1_valid(c1_valid), .c0_data(c0_data), .c1_data(c1_data),
    .c0_last(c0_last), .c1_last(c1_last), .c0_ready(c0_ready), .c1_ready(c1_ready),
    .rx_valid(rx_valid), .rx_data(rx_data),
    .spi_c(spi_c), .spi_d(spi_d), .spi_q(spi_q),
    .flash_s(flash_s), .eeprom_s(eeprom_s)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst = 1'b1; spi_lock = 1'b0;
    c0_req = 1'b0; c1_req = 1'b0; c0_valid = 1'b0; c1_valid = 1'b0;
    c0_last = 1'b0; c1_last = 1'b0; c0_data = '0; c1_data = '0;
    tick(); tick();
    rst = 1'b0;
  endtask

  // waits for ready, offers one byte, returns at the cycle rx_valid is seen
  task automatic send_byte(input bit who, input logic [7:0] d, input bit last,
                           output bit to, output logic [7:0] rx, output int cyc);
    int n = 0;
    to = 1'b0; rx = '0; cyc = 0;
    while (!(who ? c1_ready : c0_ready) && n < 50) begin tick(); n++; end
    if (!(who ? c1_ready : c0_ready)) begin to = 1'b1; return; end
    if (who) begin c1_valid = 1'b1; c1_data = d; c1_last = last; end
    else     begin c0_valid = 1'b1; c0_data = d; c0_last = last; end
    tick();
    c0_valid = 1'b0; c1_valid = 1'b0; c0_last = 1'b0; c1_last = 1'b0;
    n = 0;
    while (!rx_valid && n < 300) begin tick(); n++; end
    to = !rx_valid; rx = rx_data; cyc = n;
  endtask

  function automatic logic [7:0] pop_exp();
    if (sb.size() == 0) return 8'hxx;
    return sb.pop_front();
  endfunction

  task automatic test_reset();
    logic [16:0] obs;
    apply_reset();
    obs = {flash_s, eeprom_s, spi_c, spi_d, c0_gnt, c1_gnt, c0_ready, c1_ready, rx_valid, rx_data};
    n_vec++;
    if (obs !== RST_OUT) begin n_err++; $display("FAIL reset_outputs: got %h expected %h", obs, RST_OUT); end
  endtask

  task automatic test_single_write();
    bit to; logic [7:0] rx, e, mosi; int cyc, n, m0, bad_period;
    apply_reset();
    slv_word = '1;
    m0 = mosi_bits.size();
    c0_req = 1'b1;
    tick();
    n_vec++;
    if ({c0_gnt, c1_gnt, flash_s, eeprom_s} !== 4'b1001) begin
      n_err++; $display("FAIL gnt0_after_req: got %b expected 1001", {c0_gnt, c1_gnt, flash_s, eeprom_s});
    end
    n = 0;
    while (!c0_ready && n < 10) begin tick(); n++; end
    n_vec++;
    if (n !== CS_SETUP) begin n_err++; $display("FAIL ready_delay: got %0d expected %0d", n, CS_SETUP); end
    sb.push_back(8'hFF);
    send_byte(1'b0, 8'hA5, 1'b1, to, rx, cyc);
    e = pop_exp();
    n_vec++;
    if (to || rx !== e) begin n_err++; $display("FAIL write_rx: got %h (timeout %0d) expected %h", rx, to, e); end
    n_vec++;
    if (cyc !== 16 * CLK_DIV) begin n_err++; $display("FAIL byte_cycles: got %0d expected %0d", cyc, 16 * CLK_DIV); end
    n_vec++;
    if (mosi_bits.size() - m0 !== 8) begin
      n_err++; $display("FAIL sck_pulses: got %0d expected 8", mosi_bits.size() - m0);
    end
    mosi = '0; bad_period = 0;
    for (int i = 0; i < 8 && m0 + i < mosi_bits.size(); i++) begin
      mosi = {mosi[6:0], mosi_bits[m0 + i]};
      if (i > 0 && rise_cyc[m0 + i] - rise_cyc[m0 + i - 1] != 2 * CLK_DIV) bad_period++;
    end
    n_vec++;
    if (mosi !== 8'hA5) begin n_err++; $display("FAIL mosi_bits: got %h expected a5", mosi); end
    n_vec++;
    if (bad_period !== 0) begin n_err++; $display("FAIL sck_period: got %0d bad periods expected 0", bad_period); end
    c0_req = 1'b0;
    tick();
    n_vec++;
    if ({flash_s, c0_gnt, spi_c} !== 3'b100) begin
      n_err++; $display("FAIL cs_release: got %b expected 100", {flash_s, c0_gnt, spi_c});
    end
    repeat (8) tick();
  endtask

  task automatic test_round_robin();
    bit to; logic [7:0] rx, e; int cyc, n, bg0;
    apply_reset();
    slv_word = '1;
    bg0 = both_gnt;
    c0_req = 1'b1; c1_req = 1'b1;
    tick();
    n_vec++;
    if ({c0_gnt, c1_gnt} !== 2'b10) begin n_err++; $display("FAIL rr_first: got %b expected 10", {c0_gnt, c1_gnt}); end
    sb.push_back(8'hFF);
    send_byte(1'b0, 8'h3C, 1'b1, to, rx, cyc);
    c0_req = 1'b0;
    e = pop_exp();
    n_vec++;
    if (to || rx !== e) begin n_err++; $display("FAIL rr_c0_rx: got %h (timeout %0d) expected %h", rx, to, e); end
    n_vec++;
    if ({c0_gnt, c1_gnt, flash_s} !== 3'b001) begin
      n_err++; $display("FAIL gap_first_cycle: got %b expected 001", {c0_gnt, c1_gnt, flash_s});
    end
    n = 0;
    while (!c1_gnt && n < 30) begin tick(); n++; end
    n_vec++;
    if (n !== CS_GAP + 1) begin n_err++; $display("FAIL rr_c1_delay: got %0d expected %0d", n, CS_GAP + 1); end
    sb.push_back(8'hFF);
    send_byte(1'b1, 8'hC3, 1'b1, to, rx, cyc);
    c0_req = 1'b1;
    e = pop_exp();
    n_vec++;
    if (to || rx !== e) begin n_err++; $display("FAIL rr_c1_rx: got %h (timeout %0d) expected %h", rx, to, e); end
    n = 0;
    while (!(c0_gnt || c1_gnt) && n < 30) begin tick(); n++; end
    n_vec++;
    if ({c0_gnt, c1_gnt} !== 2'b10) begin n_err++; $display("FAIL rr_alternate: got %b expected 10", {c0_gnt, c1_gnt}); end
    c0_req = 1'b0; c1_req = 1'b0;
    repeat (20) tick();
    n_vec++;
    if (both_gnt - bg0 !== 0) begin n_err++; $display("FAIL both_granted: got %0d cycles expected 0", both_gnt - bg0); end
  endtask

  task automatic test_multi_byte_read();
    bit to; logic [7:0] rx, e, mosi; logic [7:0] tx[3]; int cyc, es0, m0;
    tx[0] = 8'h03; tx[1] = 8'h00; tx[2] = 8'h00;
    apply_reset();
    slv_word = {24'h123456, 8'h00};
    es0 = es_rise;
    m0 = mosi_bits.size();
    c1_req = 1'b1;
    sb.push_back(8'h12); sb.push_back(8'h34); sb.push_back(8'h56);
    for (int i = 0; i < 3; i++) begin
      send_byte(1'b1, tx[i], i == 2, to, rx, cyc);
      e = pop_exp();
      n_vec++;
      if (to || rx !== e) begin n_err++; $display("FAIL read_rx%0d: got %h (timeout %0d) expected %h", i, rx, to, e); end
      if (i < 2) begin
        n_vec++;
        if (eeprom_s !== 1'b0) begin n_err++; $display("FAIL cs_held%0d: got %b expected 0", i, eeprom_s); end
      end
    end
    c1_req = 1'b0;
    mosi = '0;
    for (int i = 0; i < 8 && m0 + i < mosi_bits.size(); i++) mosi = {mosi[6:0], mosi_bits[m0 + i]};
    n_vec++;
    if (mosi !== 8'h03) begin n_err++; $display("FAIL read_cmd: got %h expected 03", mosi); end
    n_vec++;
    if (es_rise - es0 !== 1) begin n_err++; $display("FAIL cs_toggles: got %0d expected 1", es_rise - es0); end
    repeat (8) tick();
  endtask

  task automatic test_abort();
    bit to; logic [7:0] rx, e; int cyc, n, m1;
    apply_reset();
    slv_word = '1;
    c0_req = 1'b1;
    sb.push_back(8'hFF);
    send_byte(1'b0, 8'h5A, 1'b0, to, rx, cyc);
    e = pop_exp();
    n_vec++;
    if (to || rx !== e) begin n_err++; $display("FAIL abort_rx: got %h (timeout %0d) expected %h", rx, to, e); end
    m1 = mosi_bits.size();
    c0_req = 1'b0;
    tick();
    n_vec++;
    if ({flash_s, c0_gnt} !== 2'b10) begin n_err++; $display("FAIL abort_cs: got %b expected 10", {flash_s, c0_gnt}); end
    c0_req = 1'b1;
    n = 0;
    while (!c0_gnt && n < 30) begin tick(); n++; end
    n_vec++;
    if (n !== CS_GAP + 1) begin n_err++; $display("FAIL abort_gap: got %0d expected %0d", n, CS_GAP + 1); end
    n_vec++;
    if (mosi_bits.size() !== m1) begin n_err++; $display("FAIL abort_sck: got %0d pulses expected 0", mosi_bits.size() - m1); end
    c0_req = 1'b0;
    repeat (10) tick();
  endtask

  task automatic test_lock();
    bit to; logic [7:0] rx, e; int cyc, bad;
    apply_reset();
    slv_word = '1;
    c0_req = 1'b1;
    tick();
    spi_lock = 1'b1;
    sb.push_back(8'hFF);
    send_byte(1'b0, 8'h11, 1'b1, to, rx, cyc);
    c0_req = 1'b0;
    c1_req = 1'b1;
    e = pop_exp();
    n_vec++;
    if (to || rx !== e) begin n_err++; $display("FAIL lock_completes: got %h (timeout %0d) expected %h", rx, to, e); end
    bad = 0;
    repeat (20) begin tick(); if (c1_gnt) bad++; end
    n_vec++;
    if (bad !== 0) begin n_err++; $display("FAIL lock_blocks: got %0d granted cycles expected 0", bad); end
    spi_lock = 1'b0;
    tick();
    n_vec++;
    if (c1_gnt !== 1'b1) begin n_err++; $display("FAIL lock_release: got %b expected 1", c1_gnt); end
    c1_req = 1'b0;
    repeat (10) tick();
  endtask

  task automatic test_reset_mid_shift();
    bit to; logic [7:0] rx, e; logic [16:0] obs; int cyc, n, m0, rv;
    apply_reset();
    slv_word = '1;
    m0 = mosi_bits.size();
    c0_req = 1'b1;
    n = 0;
    while (!c0_ready && n < 20) begin tick(); n++; end
    c0_valid = 1'b1; c0_data = 8'hF0; c0_last = 1'b1;
    tick();
    c0_valid = 1'b0; c0_last = 1'b0;
    n = 0;
    while (mosi_bits.size() < m0 + 5 && n < 200) begin tick(); n++; end
    n_vec++;
    if (n >= 200) begin n_err++; $display("FAIL reach_bit4: got %0d pulses expected 5", mosi_bits.size() - m0); end
    rv = rxv_cnt;
    rst = 1'b1; c0_req = 1'b0;
    tick();
    obs = {flash_s, eeprom_s, spi_c, spi_d, c0_gnt, c1_gnt, c0_ready, c1_ready, rx_valid, rx_data};
    n_vec++;
    if (obs !== RST_OUT) begin n_err++; $display("FAIL reset_mid_shift: got %h expected %h", obs, RST_OUT); end
    tick();
    rst = 1'b0;
    repeat (100) tick();
    n_vec++;
    if (rxv_cnt !== rv) begin n_err++; $display("FAIL no_rx_after_reset: got %0d pulses expected 0", rxv_cnt - rv); end
    c0_req = 1'b1; c1_req = 1'b1;
    tick();
    n_vec++;
    if ({c0_gnt, c1_gnt} !== 2'b10) begin n_err++; $display("FAIL restart_priority: got %b expected 10", {c0_gnt, c1_gnt}); end
    sb.push_back(8'hFF);
    send_byte(1'b0, 8'h81, 1'b1, to, rx, cyc);
    c0_req = 1'b0; c1_req = 1'b0;
    e = pop_exp();
    n_vec++;
    if (to || rx !== e) begin n_err++; $display("FAIL restart_rx: got %h (timeout %0d) expected %h", rx, to, e); end
    repeat (10) tick();
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_round_robin();
    test_multi_byte_read();
    test_abort();
    test_lock();
    test_reset_mid_shift();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
